// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-PC generator.
// Holds the address type, the reset vector and the redirect-source enum
// used both by the pc_gen priority mux and by testbench coverage.
package pc_pkg;

   typedef logic [31:0] addr_t;

   localparam addr_t RESET_VECTOR = 32'hbfc00000;

   // Which source wins the next-PC selection on a given edge.
   // REDIR_NONE means pc_q holds (stall, with or without a buffered capture).
   typedef enum logic [2:0] {
      REDIR_NONE,
      REDIR_FLUSH,
      REDIR_PEND,
      REDIR_BRANCH,
      REDIR_SEQ
   } redir_src_e;

   // Start of the next fetch group: align down to the group size, then step
   // one group. Wraps modulo 2^32 with no special handling.
   function automatic addr_t seq_next(addr_t pc, addr_t group_bytes);
      return (pc & ~(group_bytes - addr_t'(1))) + group_bytes;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: control inputs and fetch-address outputs of pc_gen.
// master = the front-end driving stalls/redirects, slave = pc_gen itself.
interface pc_gen_if #(
   parameter int FETCH_WIDTH = 1
);
   import pc_pkg::*;

   localparam int SLOT_W = $clog2(FETCH_WIDTH) + 1;

   logic              en;
   logic              flush;
   addr_t             new_pc;
   logic              branch_flag_i;
   addr_t             branch_target_address_i;
   addr_t             pc;
   logic [SLOT_W-1:0] pc_slots;
   logic              redirect_pending;
   logic              pc_adel;

   modport master (
      output en, flush, new_pc, branch_flag_i, branch_target_address_i,
      input  pc, pc_slots, redirect_pending, pc_adel
   );

   modport slave (
      input  en, flush, new_pc, branch_flag_i, branch_target_address_i,
      output pc, pc_slots, redirect_pending, pc_adel
   );

endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry holding register for a branch redirect that
// arrives while fetch is stalled. clear wins over capture; a new capture
// overwrites whatever is held.
module pc_redirect_buf
   import pc_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  capture,
   input  logic  clear,
   input  addr_t target,
   output logic  valid,
   output addr_t target_q
);

   // Buffered redirect state: reset drops it, clear consumes it, capture loads it.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         target_q <= '0;
      end else if (clear) begin
         valid    <= 1'b0;
         target_q <= '0;
      end else if (capture) begin
         valid    <= 1'b1;
         target_q <= target;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-group PC generator with stall, flush and branch redirect.
// Optional macro PC_ADEL_CHECK_EN enables the misaligned fetch-address flag
// (pc_adel) and collapses pc_slots to 1 while it is raised; undefined, the
// flag is tied low and no check logic exists.
module pc_gen
   import pc_pkg::*;
#(
   parameter addr_t RESET_PC    = RESET_VECTOR,
   parameter int    FETCH_WIDTH = 1
)(
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.slave  bus
);

   localparam int    LOG_FW      = $clog2(FETCH_WIDTH);
   localparam int    SLOT_W      = LOG_FW + 1;
   localparam addr_t GROUP_BYTES = addr_t'(4 * FETCH_WIDTH);

   addr_t             pc_q;
   addr_t             pc_next;
   addr_t             pc_out;
   redir_src_e        redir_src;
   logic              pend_valid;
   addr_t             pend_target;
   logic              pend_capture;
   logic              pend_clear;
   logic              adel;
   logic [SLOT_W-1:0] slots_raw;

   // Redirect priority: flush, then held redirect, then live branch, then sequential.
   always_comb begin
      redir_src = REDIR_NONE;
      if (bus.flush) begin
         redir_src = REDIR_FLUSH;
      end else if (bus.en) begin
         if (pend_valid)
            redir_src = REDIR_PEND;
         else if (bus.branch_flag_i)
            redir_src = REDIR_BRANCH;
         else
            redir_src = REDIR_SEQ;
      end
   end

   // Next-PC mux driven by the selected redirect source.
   always_comb begin
      pc_next = pc_q;
      case (redir_src)
         REDIR_FLUSH:  pc_next = bus.new_pc;
         REDIR_PEND:   pc_next = pend_target;
         REDIR_BRANCH: pc_next = bus.branch_target_address_i;
         REDIR_SEQ:    pc_next = seq_next(pc_q, GROUP_BYTES);
         default:      pc_next = pc_q;
      endcase
   end

   // Fetch PC register.
   always_ff @(posedge clk) begin
      if (rst)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_next;
   end

   // A branch seen during a stall is parked; a flush discards it, and the
   // first advancing edge consumes it (dropping any simultaneous branch).
   assign pend_capture = !bus.flush && !bus.en && bus.branch_flag_i;
   assign pend_clear   = (redir_src == REDIR_FLUSH) || (redir_src == REDIR_PEND);

   pc_redirect_buf u_redirect_buf (
      .clk      (clk),
      .rst      (rst),
      .capture  (pend_capture),
      .clear    (pend_clear),
      .target   (bus.branch_target_address_i),
      .valid    (pend_valid),
      .target_q (pend_target)
   );

   // Flush target is visible in the same cycle through this bypass.
   assign pc_out = bus.flush ? bus.new_pc : pc_q;

   // Slots left in the group from the word offset of pc within the group.
   generate
      if (FETCH_WIDTH == 1) begin : g_single
         assign slots_raw = 1'b1;
      end else begin : g_multi
         assign slots_raw = SLOT_W'(FETCH_WIDTH) - {1'b0, pc_out[LOG_FW+1:2]};
      end
   endgenerate

`ifdef PC_ADEL_CHECK_EN
   // Misaligned address still issues, but only the faulting slot is presented.
   assign adel         = |pc_out[1:0];
   assign bus.pc_slots = adel ? SLOT_W'(1) : slots_raw;
`else
   assign adel         = 1'b0;
   assign bus.pc_slots = slots_raw;
`endif

   assign bus.pc               = pc_out;
   assign bus.pc_adel          = adel;
   assign bus.redirect_pending = pend_valid;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-PC generator for the GuGuMIPS front end; it is the successor to the single-issue PC register. It produces a fetch-group address of FETCH_WIDTH instructions per cycle, honours stalls, and arbitrates flush and branch redirects. Branch redirects that arrive during a stall are buffered until fetch advances. It sits ahead of the instruction fetch stage and the I-cache request port.

## Interface
- RESET_PC, 32'hbfc00000, address loaded on reset
- FETCH_WIDTH, 1, instructions per fetch group; legal values 1, 2, 4
- SLOT_W, $clog2(FETCH_WIDTH)+1, width of the slot-count output (derived)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1)
- en  in  1  fetch advance; 0 = stall
- flush  in  1  exception/ERET redirect
- new_pc  in  32  flush target
- branch_flag_i  in  1  branch-resolved redirect request
- branch_target_address_i  in  32  branch target
- pc  out  32  current fetch address; combinational `flush ? new_pc : pc_q`
- pc_slots  out  SLOT_W  valid instructions in the group: FETCH_WIDTH − pc[idx], where idx = [$clog2(FETCH_WIDTH)+1:2] (always 1 when FETCH_WIDTH = 1)
- redirect_pending  out  1  a buffered branch redirect is held
- pc_adel  out  1  fetch-address error flag (see Configuration)

## Operation
- Registered state:
  - pc_q, 32 bits
  - pend_valid, 1 bit
  - pend_target, 32 bits
- Group byte size G = 4·FETCH_WIDTH.
- Sequential next PC = (pc_q & ~(G−1)) + G. Arithmetic is modulo 2^32; the PC wraps 32'hffff_fff0 → 0 silently.
- Per-edge priority, highest first:
  1. rst: pc_q←RESET_PC, pend_valid←0, pend_target←0.
  2. flush: pc_q←new_pc, pend cleared. A simultaneous branch_flag_i is discarded.
  3. en && pend_valid: pc_q←pend_target, pend cleared. A simultaneous branch_flag_i is discarded.
  4. en && branch_flag_i: pc_q←branch_target_address_i.
  5. en: pc_q←sequential next.
  6. !en && branch_flag_i: pend_valid←1, pend_target←branch_target_address_i. The latest request overwrites any held one, because the branch unit holds its request stable through the stall. pc_q holds.
  7. Otherwise hold all state.
- redirect_pending = pend_valid.
- Redirect targets are not realigned. A mid-group target yields pc_slots < FETCH_WIDTH; the next sequential PC realigns to the group boundary.

## Timing
- Reset values:
  - pc = RESET_PC
  - pc_slots = FETCH_WIDTH − RESET_PC[idx]
  - redirect_pending = 0
  - pc_adel = 0
- Latency:
  - flush: zero cycles on pc, through the combinational bypass; one edge to update pc_q.
  - Branch with en=1: pc shows the target on the cycle after the request.
  - Branch during a stall: pc shows the target on the cycle after the first edge with en=1.
- Reset asserted mid-stall with a pending redirect drops the redirect.
- flush and rst with en=0 still take effect; en gates only priorities 3–5.

## Configuration
- Macro `PC_ADEL_CHECK_EN`.
- Defined:
  - pc_adel = (pc[1:0] != 0), evaluated on the bypassed pc.
  - A misaligned address is still issued unchanged.
  - pc_slots is forced to 1 while pc_adel = 1, so only the faulting slot is presented.
- Undefined: pc_adel tied 0; no check logic is synthesised.

## Structure
- Shared package `pc_pkg`:
  - `addr_t` (logic [31:0])
  - `RESET_VECTOR` constant (32'hbfc00000)
  - `redir_src_e` enum {REDIR_NONE, REDIR_FLUSH, REDIR_PEND, REDIR_BRANCH, REDIR_SEQ}, used by the priority mux and by bench coverage
- Sub-module `pc_redirect_buf`:
  - Holds pend_valid/pend_target.
  - Inputs: clk, rst, capture, clear, target.
  - Outputs: valid, target.
- Top-level holds pc_q, the priority mux, and the slot/adel logic.

## Test plan
- Reset, FETCH_WIDTH=4, en=1 for 3 cycles → pc = bfc00000, bfc00010, bfc00020; pc_slots = 4 each.
- FETCH_WIDTH=4, branch to 8000_0008 with en=1 → next pc = 8000_0008, pc_slots = 2; following pc = 8000_0010, pc_slots = 4.
- en=0, branch_flag_i to 8000_1000 for 2 cycles → redirect_pending = 1, pc held. Then en=1 together with branch_flag_i to 9000_0000 → next pc = 8000_1000 and redirect_pending = 0.
- flush with new_pc = bfc00380 while a redirect is pending and en=0 → pc = bfc00380 in the same cycle; redirect_pending = 0 after the edge.
- FETCH_WIDTH=1, pc_q = ffff_fffc, en=1 → next pc = 0000_0000.
- With `PC_ADEL_CHECK_EN`: branch to 8000_0002 → pc_adel = 1, pc_slots = 1. Without the macro: pc_adel = 0.
